// File: rtl/multi_channel_pulse_sequencer_avms_pkg.sv
// pulse_seq_pkg: register map, control/status bit positions and sequencer states
package pulse_seq_pkg;
    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_STATUS  = 1;
    localparam int ADDR_PERIOD  = 2;
    localparam int ADDR_CH_EN   = 3;
    localparam int ADDR_CH_BASE = 4;
    localparam int CTRL_START   = 0;
    localparam int CTRL_STOP    = 1;
    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_ABORTED   = 2;
    localparam int ST_CFG_ERR   = 3;
    localparam int FIELD_LO     = 8;
    localparam int FIELD_HI     = 15;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/multi_channel_pulse_sequencer_avms_channel.sv
// pulse_seq_channel: shadowed delay/width/enable, window compare and registered pulse output
module pulse_seq_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             latch,
    input  logic             run,
    input  logic             en,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] cnt,
    output logic             pulse
);
    logic             en_s;
    logic [CNT_W-1:0] delay_s;
    logic [CNT_W-1:0] width_s;

    // shadow re-latch at period boundaries; window end is one bit wider so delay+width never wraps
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            en_s    <= 1'b0;
            delay_s <= '0;
            width_s <= '0;
            pulse   <= 1'b0;
        end else begin
            if (latch) begin
                en_s    <= en;
                delay_s <= delay;
                width_s <= width;
            end
            pulse <= run && en_s && cnt >= delay_s && {1'b0, cnt} < {1'b0, delay_s} + {1'b0, width_s};
        end
endmodule

// File: rtl/multi_channel_pulse_sequencer_avms.sv
// multi_channel_pulse_sequencer_avms: Avalon-MM configured multi-channel pulse sequencer
// (optional tick prescaler enabled by defining PULSE_SEQ_PRESCALE_EN)
module multi_channel_pulse_sequencer_avms
    import pulse_seq_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_W       = 5,
    parameter int CLK_PER_TICK = 100
) (
    input  logic                    ctrl_clk_i,
    input  logic                    ctrl_rst_n_i,
    input  logic [ADDR_W-1:0]       slave_addr,
    input  logic [DATA_WIDTH/8-1:0] slave_byteenable,
    input  logic                    slave_read,
    input  logic                    slave_write,
    input  logic [DATA_WIDTH-1:0]   slave_writedata,
    output logic [DATA_WIDTH-1:0]   slave_readdata,
    output logic [NUM_CH-1:0]       pulse_o,
    output logic                    busy_o,
    output logic                    done_irq_o
);
    state_t            state;
    logic [7:0]        num_cycles, num_cycles_s, cycles_done, cd_next;
    logic              done, aborted, cfg_err;
    logic [CNT_W-1:0]  period, period_s, cnt;
    logic [NUM_CH-1:0] ch_en;
    logic [CNT_W-1:0]  delay [NUM_CH];
    logic [CNT_W-1:0]  width [NUM_CH];
    logic              tick, wrap, latch, run, start, stop, wr_ctrl, wr_status;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic              unused;

    assign unused     = ^{slave_byteenable, slave_writedata[DATA_WIDTH-1:CNT_W], CLK_PER_TICK != 0};
    assign wr_ctrl    = slave_write && slave_addr == ADDR_W'(ADDR_CTRL);
    assign wr_status  = slave_write && slave_addr == ADDR_W'(ADDR_STATUS);
    assign start      = wr_ctrl && slave_writedata[CTRL_START];
    assign stop       = wr_ctrl && slave_writedata[CTRL_STOP];
    assign run        = state == RUN;
    assign wrap       = run && tick && cnt == period_s - CNT_W'(1);
    assign latch      = state == LOAD || wrap;
    assign cd_next    = &cycles_done ? cycles_done : cycles_done + 8'd1;
    assign busy_o     = state != IDLE;
    assign done_irq_o = done;

`ifdef PULSE_SEQ_PRESCALE_EN
    localparam int PW = $clog2(CLK_PER_TICK + 1);
    logic [PW-1:0] presc;
    assign tick = presc == PW'(CLK_PER_TICK - 1);
    // timebase divider, realigned in LOAD so the first count lasts a full tick
    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i)
        if (!ctrl_rst_n_i) presc <= '0;
        else presc <= (state == LOAD || tick) ? '0 : presc + PW'(1);
`else
    assign tick = 1'b1;
`endif

    // register read decode; unmapped words read as zero
    always_comb begin
        rd_mux = '0;
        if (slave_addr == ADDR_W'(ADDR_CTRL)) rd_mux[FIELD_HI:FIELD_LO] = num_cycles;
        if (slave_addr == ADDR_W'(ADDR_STATUS)) begin
            rd_mux[ST_BUSY]           = busy_o;
            rd_mux[ST_DONE]           = done;
            rd_mux[ST_ABORTED]        = aborted;
            rd_mux[ST_CFG_ERR]        = cfg_err;
            rd_mux[FIELD_HI:FIELD_LO] = cycles_done;
        end
        if (slave_addr == ADDR_W'(ADDR_PERIOD)) rd_mux[CNT_W-1:0] = period;
        if (slave_addr == ADDR_W'(ADDR_CH_EN)) rd_mux[NUM_CH-1:0] = ch_en;
        for (int k = 0; k < NUM_CH; k++) begin
            if (slave_addr == ADDR_W'(ADDR_CH_BASE + 2 * k)) rd_mux[CNT_W-1:0] = delay[k];
            if (slave_addr == ADDR_W'(ADDR_CH_BASE + 2 * k + 1)) rd_mux[CNT_W-1:0] = width[k];
        end
    end

    // read data with latency 1, held between reads
    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i)
        if (!ctrl_rst_n_i) slave_readdata <= '0;
        else if (slave_read) slave_readdata <= rd_mux;

    // configuration registers, sticky status and the IDLE/LOAD/RUN sequencer
    always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i)
        if (!ctrl_rst_n_i) begin
            state        <= IDLE;
            num_cycles   <= '0;
            num_cycles_s <= '0;
            cycles_done  <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            cfg_err      <= 1'b0;
            period       <= '0;
            period_s     <= '0;
            cnt          <= '0;
            ch_en        <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                delay[k] <= '0;
                width[k] <= '0;
            end
        end else begin
            if (wr_ctrl) num_cycles <= slave_writedata[FIELD_HI:FIELD_LO];
            if (slave_write && slave_addr == ADDR_W'(ADDR_PERIOD)) period <= slave_writedata[CNT_W-1:0];
            if (slave_write && slave_addr == ADDR_W'(ADDR_CH_EN)) ch_en <= slave_writedata[NUM_CH-1:0];
            for (int k = 0; k < NUM_CH; k++) begin
                if (slave_write && slave_addr == ADDR_W'(ADDR_CH_BASE + 2 * k)) delay[k] <= slave_writedata[CNT_W-1:0];
                if (slave_write && slave_addr == ADDR_W'(ADDR_CH_BASE + 2 * k + 1)) width[k] <= slave_writedata[CNT_W-1:0];
            end
            if (wr_status && slave_writedata[ST_DONE]) done <= 1'b0;
            if (wr_status && slave_writedata[ST_ABORTED]) aborted <= 1'b0;
            if (wr_status && slave_writedata[ST_CFG_ERR]) cfg_err <= 1'b0;
            case (state)
                IDLE:
                    if (start && !stop) begin
                        if (period == '0) cfg_err <= 1'b1;
                        else state <= LOAD;
                    end
                LOAD:
                    if (stop) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else begin
                        period_s     <= period;
                        num_cycles_s <= num_cycles;
                        cnt          <= '0;
                        cycles_done  <= '0;
                        state        <= RUN;
                    end
                RUN:
                    if (stop) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (wrap) begin
                        cnt          <= '0;
                        cycles_done  <= cd_next;
                        period_s     <= period == '0 ? period_s : period;
                        num_cycles_s <= num_cycles;
                        if (num_cycles_s != '0 && cd_next == num_cycles_s) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else if (tick) cnt <= cnt + CNT_W'(1);
                default: state <= IDLE;
            endcase
        end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pulse_seq_channel #(.CNT_W(CNT_W)) u_ch (
            .clk   (ctrl_clk_i),
            .rst_n (ctrl_rst_n_i),
            .latch (latch),
            .run   (run),
            .en    (ch_en[c]),
            .delay (delay[c]),
            .width (width[c]),
            .cnt   (cnt),
            .pulse (pulse_o[c])
        );
    end
endmodule

// File: tb/tb_multi_channel_pulse_sequencer_avms.sv
// tb_multi_channel_pulse_sequencer_avms: directed register-table and timing-scenario checks
module tb_multi_channel_pulse_sequencer_avms;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] slave_addr = '0;
    logic [3:0]        slave_byteenable = 4'hF;
    logic              slave_read = 1'b0;
    logic              slave_write = 1'b0;
    logic [31:0]       slave_writedata = '0;
    logic [31:0]       slave_readdata;
    logic [NUM_CH-1:0] pulse_o;
    logic              busy_o;
    logic              done_irq_o;

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    int          n;
    logic [31:0] h [NUM_CH];
    logic [31:0] hb;
    logic [31:0] v;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       exp;
    } vec_t;
    vec_t tbl [11];

    multi_channel_pulse_sequencer_avms dut (
        .ctrl_clk_i       (clk),
        .ctrl_rst_n_i     (rst_n),
        .slave_addr       (slave_addr),
        .slave_byteenable (slave_byteenable),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_readdata   (slave_readdata),
        .pulse_o          (pulse_o),
        .busy_o           (busy_o),
        .done_irq_o       (done_irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        slave_write = w;
        slave_addr = a;
        slave_writedata = d;
        @(posedge clk);
        #1;
        slave_write = 1'b0;
        cyc++;
        if (cyc >= 0 && cyc < 32) begin
            for (int k = 0; k < NUM_CH; k++) h[k][cyc] = pulse_o[k];
            hb[cyc] = busy_o;
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        slave_read = 1'b1;
        slave_addr = a;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
        d = slave_readdata;
    endtask

    task automatic clear_hist();
        cyc = -1;
        hb = '0;
        for (int k = 0; k < NUM_CH; k++) h[k] = '0;
    endtask

    task automatic wait_idle(input int bound, output int cnt);
        cnt = 0;
        while (busy_o && cnt < bound) begin
            step(1'b0, '0, '0);
            cnt++;
        end
        if (busy_o) check("wait_idle_timeout", 32'(busy_o), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{5'd2,  32'h0000_1234, 32'h0000_1234};
        tbl[1]  = '{5'd2,  32'hABCD_5678, 32'h0000_5678};
        tbl[2]  = '{5'd3,  32'hFFFF_FFFF, 32'h0000_000F};
        tbl[3]  = '{5'd4,  32'h0000_0007, 32'h0000_0007};
        tbl[4]  = '{5'd5,  32'h0001_FFFF, 32'h0000_FFFF};
        tbl[5]  = '{5'd11, 32'h0000_00AA, 32'h0000_00AA};
        tbl[6]  = '{5'd12, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[7]  = '{5'd31, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[8]  = '{5'd0,  32'h0000_0500, 32'h0000_0500};
        tbl[9]  = '{5'd0,  32'h0000_FF02, 32'h0000_FF00};
        tbl[10] = '{5'd1,  32'hFFFF_FFFF, 32'h0000_0000};
        clear_hist();

        repeat (2) @(posedge clk);
        #1;
        check("reset_pulse", 32'(pulse_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_irq", 32'(done_irq_o), 32'h0);
        check("reset_readdata", slave_readdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, v);
            check($sformatf("reg_tbl_%0d", i), v, tbl[i].exp);
        end
        rd(5'd2, v);
        slave_addr = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        check("readdata_hold", slave_readdata, 32'h0000_5678);

        do_reset();
        step(1'b1, 5'd2, 32'd10);
        step(1'b1, 5'd3, 32'h1);
        step(1'b1, 5'd4, 32'd2);
        step(1'b1, 5'd5, 32'd3);
        clear_hist();
        step(1'b1, 5'd0, 32'h0000_0201);
        repeat (31) step(1'b0, '0, '0);
        check("burst2_ch0", h[0], 32'h0001_C070);
        check("burst2_ch1_off", h[1], 32'h0);
        check("burst2_busy", hb, 32'h001F_FFFF);
        rd(5'd1, v);
        check("burst2_status", v, 32'h0000_0202);
        check("burst2_irq", 32'(done_irq_o), 32'h1);
        step(1'b1, 5'd1, 32'h2);
        rd(5'd1, v);
        check("done_w1c", v, 32'h0000_0200);
        check("done_w1c_irq", 32'(done_irq_o), 32'h0);

        step(1'b1, 5'd6, 32'd8);
        step(1'b1, 5'd7, 32'd5);
        step(1'b1, 5'd8, 32'd1);
        step(1'b1, 5'd9, 32'd0);
        step(1'b1, 5'd3, 32'h7);
        clear_hist();
        step(1'b1, 5'd0, 32'h0000_0201);
        repeat (31) step(1'b0, '0, '0);
        check("trunc_ch0", h[0], 32'h0001_C070);
        check("trunc_ch1", h[1], 32'h0030_0C00);
        check("width0_ch2", h[2], 32'h0);
        rd(5'd1, v);
        check("trunc_status", v, 32'h0000_0202);
        step(1'b1, 5'd1, 32'h2);

        step(1'b1, 5'd3, 32'h1);
        clear_hist();
        step(1'b1, 5'd0, 32'h0000_0001);
        repeat (24) step(1'b0, '0, '0);
        check("cont_pre_stop_pulse", 32'(pulse_o[0]), 32'h1);
        step(1'b1, 5'd0, 32'h0000_0002);
        step(1'b0, '0, '0);
        check("stop_pulse", 32'(pulse_o), 32'h0);
        check("stop_busy", 32'(busy_o), 32'h0);
        rd(5'd1, v);
        check("stop_status", v, 32'h0000_0204);
        check("stop_irq", 32'(done_irq_o), 32'h0);
        step(1'b1, 5'd1, 32'h4);
        rd(5'd1, v);
        check("aborted_w1c", v, 32'h0000_0200);

        step(1'b1, 5'd2, 32'd0);
        step(1'b1, 5'd0, 32'h0000_0001);
        step(1'b0, '0, '0);
        check("cfg_err_busy", 32'(busy_o), 32'h0);
        rd(5'd1, v);
        check("cfg_err_status", v, 32'h0000_0208);
        step(1'b1, 5'd1, 32'h8);
        rd(5'd1, v);
        check("cfg_err_w1c", v, 32'h0000_0200);

        step(1'b1, 5'd2, 32'd10);
        clear_hist();
        step(1'b1, 5'd0, 32'h0000_0301);
        repeat (14) step(1'b0, '0, '0);
        step(1'b1, 5'd0, 32'h0000_0301);
        wait_idle(100, n);
        check("restart_ignored_len", 32'(n), 32'd16);
        rd(5'd1, v);
        check("restart_ignored_status", v, 32'h0000_0302);
        step(1'b1, 5'd1, 32'h2);

        step(1'b1, 5'd0, 32'h0000_0200);
        clear_hist();
        step(1'b1, 5'd0, 32'h0000_0201);
        step(1'b0, '0, '0);
        step(1'b1, 5'd4, 32'd5);
        repeat (28) step(1'b0, '0, '0);
        check("live_delay_ch0", h[0], 32'h000E_0070);
        wait_idle(100, n);
        step(1'b1, 5'd1, 32'h2);

        step(1'b1, 5'd4, 32'd2);
        clear_hist();
        step(1'b1, 5'd0, 32'h0000_0001);
        repeat (4) step(1'b0, '0, '0);
        rd(5'd2, v);
        check("midrun_read", v, 32'd10);
        check("midrun_pulse", 32'(pulse_o[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", 32'(pulse_o), 32'h0);
        check("async_rst_busy", 32'(busy_o), 32'h0);
        check("async_rst_readdata", slave_readdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 12; a++) begin
            rd(ADDR_W'(a), v);
            check($sformatf("post_rst_reg_%0d", a), v, 32'h0);
        end
        step(1'b0, '0, '0);
        check("post_rst_pulse", 32'(pulse_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_channel_pulse_sequencer_avms.md
Name: multi_channel_pulse_sequencer_avms

Overview:
Parametrised successor to the fixed laser/DLP/XTRIG controller: NUM_CH independent pulse outputs (lasers, DLP, XTRIG, spare) driven from one shared period counter. Each channel has its own programmable delay, width and enable. Supports N-cycle bursts or continuous run, start/stop/abort and readable status. Configured from Nios II over a single-clock Avalon-MM slave; sits between the system interconnect and the illumination/camera-trigger pins.

Parameters:
NUM_CH, 4, number of pulse output channels (1..8)
CNT_W, 16, width of period/delay/width counters and registers
DATA_WIDTH, 32, Avalon data width; must be 32
ADDR_W, 5, Avalon word-address width; must satisfy 4+2*NUM_CH <= 2**ADDR_W
CLK_PER_TICK, 100, clock cycles per timebase tick (used only with PULSE_SEQ_PRESCALE_EN)

Ports:
ctrl_clk_i  in  1  single clock for slave and sequencer
ctrl_rst_n_i  in  1  reset; asynchronous assert, active-low
slave_addr  in  ADDR_W  word address
slave_byteenable  in  DATA_WIDTH/8  ignored; full-word writes only
slave_read  in  1  read strobe
slave_write  in  1  write strobe
slave_writedata  in  DATA_WIDTH  write data
slave_readdata  out  DATA_WIDTH  read data, fixed read latency 1
pulse_o  out  NUM_CH  channel outputs, registered
busy_o  out  1  high while sequencer is not in IDLE
done_irq_o  out  1  level; equals STATUS.done

Behaviour:
- Reset: all registers 0, pulse_o=0, busy_o=0, done_irq_o=0, slave_readdata=0, FSM=IDLE.
- Register map (word addresses):
  - 0 CTRL: [0] start (W, self-clearing), [1] stop (W, self-clearing), [15:8] num_cycles (R/W; 0 = continuous).
  - 1 STATUS: [0] busy, [1] done (sticky, write-1-to-clear), [2] aborted (sticky, W1C), [3] cfg_err (sticky, W1C), [15:8] cycles_done.
  - 2 PERIOD: [CNT_W-1:0].
  - 3 CH_EN: [NUM_CH-1:0].
  - 4+2k DELAY_k; 5+2k WIDTH_k.
  - Unmapped addresses read 0; writes to them are ignored.
- Read: slave_readdata is updated on the clock edge after slave_read; otherwise it holds.
- FSM states IDLE, LOAD, RUN.
  - IDLE->LOAD on start if PERIOD != 0. If PERIOD == 0: set cfg_err and stay in IDLE.
  - LOAD (1 cycle): copy PERIOD, CH_EN, DELAY/WIDTH and num_cycles into shadow registers; clear cnt and cycles_done.
  - RUN: cnt increments each tick from 0 to PERIOD_s-1, then wraps to 0.
  - At each wrap: cycles_done increments (saturating at 255) and shadow registers re-latch, so live writes take effect at the next period boundary only.
  - RUN->IDLE when cycles_done reaches num_cycles_s (num_cycles_s != 0): set done.
  - stop in RUN -> IDLE immediately: set aborted; done is not set.
  - start while in RUN is ignored. Simultaneous start+stop: stop wins.
- Channel k output: pulse_o[k] is registered high when en_s[k] && cnt >= delay_s[k] && cnt < delay_s[k]+width_s[k].
  - The sum is computed CNT_W+1 bits wide; there is no wrap.
  - Output lags cnt by exactly 1 clock.
  - width 0 means the channel never pulses. delay >= PERIOD means the channel never pulses.
  - delay+width > PERIOD: the pulse is truncated at the wrap; it does not carry into the next period.
- Leaving RUN for any reason forces pulse_o=0 on the next clock.
- Reset asserted mid-run: all outputs go 0 asynchronously; the configuration registers are lost.

Optional Feature:
PULSE_SEQ_PRESCALE_EN.
- Defined: a prescaler counting 0..CLK_PER_TICK-1 generates a 1-clock tick; cnt advances only on tick. The prescaler resets in LOAD. Delay/width/period are in ticks (e.g. 1 us at 100 MHz).
- Undefined: tick is tied to 1; all timing is in clock cycles and CLK_PER_TICK is unused.

Decomposition:
- Package pulse_seq_pkg holds:
  - register address constants (ADDR_CTRL=0, ADDR_STATUS=1, ADDR_PERIOD=2, ADDR_CH_EN=3, ADDR_CH_BASE=4);
  - CTRL/STATUS bit-index constants;
  - the FSM state enum (IDLE/LOAD/RUN).
- One sub-module, pulse_seq_channel: per-channel shadow delay/width, window compare and registered output. It is instantiated NUM_CH times by a generate loop.

Test Plan:
- PERIOD=10, CH_EN=1, DELAY0=2, WIDTH0=3, num_cycles=2, start -> pulse_o[0] high 3 clocks per period, twice; done=1, busy=0, cycles_done=2.
- DELAY1=8, WIDTH1=5, PERIOD=10 -> pulse_o[1] high only on cnt 8,9 each period, with no spill at cnt 0; WIDTH=0 on any channel -> channel stays low.
- num_cycles=0 run, stop after 25 clocks -> pulse_o=0 next clock, aborted=1, done=0; W1C of aborted clears it.
- PERIOD=0, start -> cfg_err=1, busy stays 0; start while running -> ignored, cycles_done unaffected.
- Rewrite DELAY0 from 2 to 5 mid-period -> the current period still uses 2, the next period uses 5.
- Assert ctrl_rst_n_i mid-pulse -> pulse_o=0 immediately; all registers read 0 after release.
